// File: rtl/sfp_tx_scheduler.sv
// -----------------------------------------------------------------------------
// sfp_tx_scheduler
//
// Shares one 32-bit GT TX lane between two stream requesters (ch0 = video,
// ch1 = auxiliary/control). Each granted burst is framed with per-channel
// START/END K-words, empty cycles carry the idle word, and a clock-correction
// sequence is inserted periodically. Lives in the tx_user_clk domain between
// the encoders and the transceiver.
//
// Ports:
//   clk           TX user clock
//   rst           synchronous active-high reset
//   tx_enable     link up; new grants are only issued while high
//   ch0_valid     ch0 payload valid
//   ch0_ready     ch0 payload accepted this cycle
//   ch0_data      ch0 payload word
//   ch0_last      ch0 final beat of frame
//   ch1_valid     ch1 payload valid
//   ch1_ready     ch1 payload accepted this cycle
//   ch1_data      ch1 payload word
//   ch1_last      ch1 final beat of frame
//   gt_txdata     registered lane data
//   gt_txcharisk  registered K-character flags
//   busy          high in any state other than ARB
//
// Optional feature macro: SFP_TX_SCHED_STATS_EN
//   When defined, adds ch0_bursts[15:0], ch1_bursts[15:0] (count TAIL beats
//   per channel) and cc_count[15:0] (counts CC entries). All wrap at 16 bits
//   and are cleared by rst. When undefined these ports do not exist.
//
// Parameter legal ranges: CC_PERIOD 16..65535, CC_LEN 1..15,
// MAX_BURST 2..65535.
// -----------------------------------------------------------------------------
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ARB     | idle word on lane; service pending CC first, else grant (RR)
// CC      | CC_WORD for CC_LEN cycles
// HDR     | START marker of the granted channel, one cycle
// PAYLOAD | forward granted channel's beats; idle word when it stalls
// TAIL    | END marker of the granted channel, one cycle
//
module sfp_tx_scheduler #(
  parameter logic [31:0] START0    = 32'h55a105bc,
  parameter logic [31:0] END0      = 32'h55a107bc,
  parameter logic [31:0] START1    = 32'h55a106bc,
  parameter logic [31:0] END1      = 32'h55a108bc,
  parameter logic [31:0] IDLE_WORD = 32'h55a109bc,
  parameter logic [31:0] CC_WORD   = 32'h1c1c1cbc,
  parameter int unsigned CC_PERIOD = 5000,
  parameter int unsigned CC_LEN    = 4,
  parameter int unsigned MAX_BURST = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_enable,
  input  logic        ch0_valid,
  output logic        ch0_ready,
  input  logic [31:0] ch0_data,
  input  logic        ch0_last,
  input  logic        ch1_valid,
  output logic        ch1_ready,
  input  logic [31:0] ch1_data,
  input  logic        ch1_last,
  output logic [31:0] gt_txdata,
  output logic [3:0]  gt_txcharisk,
  output logic        busy
`ifdef SFP_TX_SCHED_STATS_EN
  ,
  output logic [15:0] ch0_bursts,
  output logic [15:0] ch1_bursts,
  output logic [15:0] cc_count
`endif
);

  localparam logic [3:0]  K_CTRL = 4'b0001;
  localparam logic [3:0]  K_CC   = 4'b1111;
  localparam logic [3:0]  K_DATA = 4'b0000;

  // Terminal-count values for the three timers.
  localparam logic [15:0] CC_TC        = 16'(CC_PERIOD - 1);
  localparam logic [3:0]  CC_LEFT_INIT = 4'(CC_LEN - 1);
  localparam logic [15:0] BEAT_TC      = 16'(MAX_BURST - 1);

  typedef enum logic [2:0] {
    ST_ARB     = 3'd0,
    ST_CC      = 3'd1,
    ST_HDR     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_TAIL    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;   // 0 = ch0, 1 = ch1
  logic        rr_q, rr_d;         // channel preferred when both are valid
  logic [3:0]  cc_left_q, cc_left_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] cc_cnt_q;
  logic        cc_pending_q;
  logic        cc_wrap;
  logic        cc_take;
  logic [31:0] word_d;
  logic [3:0]  k_d;

  // Granted-channel view of the payload interface.
  logic        g_valid;
  logic [31:0] g_data;
  logic        g_last;

  assign g_valid = grant_q ? ch1_valid : ch0_valid;
  assign g_data  = grant_q ? ch1_data  : ch0_data;
  assign g_last  = grant_q ? ch1_last  : ch0_last;

  assign busy    = (state_q != ST_ARB);
  assign cc_wrap = (cc_cnt_q == CC_TC);

  // ---------------------------------------------------------------------------
  // Next-state, lane word selection and ready generation
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    cc_left_d  = cc_left_q;
    beat_cnt_d = beat_cnt_q;
    cc_take    = 1'b0;
    word_d     = IDLE_WORD;
    k_d        = K_CTRL;
    ch0_ready  = 1'b0;
    ch1_ready  = 1'b0;

    case (state_q)
      ST_ARB: begin
        // Clock correction always wins over a new grant so its latency is
        // bounded by one burst.
        if (cc_pending_q) begin
          cc_take   = 1'b1;
          cc_left_d = CC_LEFT_INIT;
          state_d   = ST_CC;
        end else if (tx_enable && (ch0_valid || ch1_valid)) begin
          if (ch0_valid && ch1_valid) begin
            grant_d = rr_q;
          end else begin
            grant_d = ch1_valid;
          end
          rr_d    = ~grant_d;
          state_d = ST_HDR;
        end
      end

      ST_CC: begin
        word_d = CC_WORD;
        k_d    = K_CC;
        if (cc_left_q == 4'd0) begin
          state_d = ST_ARB;
        end else begin
          cc_left_d = cc_left_q - 4'd1;
        end
      end

      ST_HDR: begin
        word_d     = grant_q ? START1 : START0;
        beat_cnt_d = 16'd0;
        state_d    = ST_PAYLOAD;
      end

      ST_PAYLOAD: begin
        // Ready depends only on state and grant, never on valid.
        ch0_ready = ~grant_q;
        ch1_ready = grant_q;
        if (g_valid) begin
          word_d     = g_data;
          k_d        = K_DATA;
          beat_cnt_d = beat_cnt_q + 16'd1;
          // last and the MAX_BURST-th beat together give a single exit.
          if (g_last || (beat_cnt_q == BEAT_TC)) begin
            state_d = ST_TAIL;
          end
        end
      end

      ST_TAIL: begin
        word_d  = grant_q ? END1 : END0;
        state_d = ST_ARB;
      end

      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and lane output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ARB;
      grant_q      <= 1'b0;
      rr_q         <= 1'b0;
      cc_left_q    <= 4'd0;
      beat_cnt_q   <= 16'd0;
      gt_txdata    <= IDLE_WORD;
      gt_txcharisk <= K_CTRL;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      cc_left_q    <= cc_left_d;
      beat_cnt_q   <= beat_cnt_d;
      gt_txdata    <= word_d;
      gt_txcharisk <= k_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Clock-correction request timer. Free-running regardless of tx_enable.
  // Taking the request has priority over a coincident wrap, so a wrap that
  // lands while a request is still pending is absorbed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_cnt_q     <= 16'd0;
      cc_pending_q <= 1'b0;
    end else begin
      cc_cnt_q <= cc_wrap ? 16'd0 : (cc_cnt_q + 16'd1);
      if (cc_take) begin
        cc_pending_q <= 1'b0;
      end else if (cc_wrap) begin
        cc_pending_q <= 1'b1;
      end
    end
  end

`ifdef SFP_TX_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ch0_bursts <= 16'd0;
      ch1_bursts <= 16'd0;
      cc_count   <= 16'd0;
    end else begin
      if ((state_q == ST_TAIL) && !grant_q) begin
        ch0_bursts <= ch0_bursts + 16'd1;
      end
      if ((state_q == ST_TAIL) && grant_q) begin
        ch1_bursts <= ch1_bursts + 16'd1;
      end
      if (cc_take) begin
        cc_count <= cc_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sfp_tx_scheduler.sv
`timescale 1ns/1ps
module tb_sfp_tx_scheduler;

  localparam logic [31:0] W_START0 = 32'h55a105bc;
  localparam logic [31:0] W_END0   = 32'h55a107bc;
  localparam logic [31:0] W_START1 = 32'h55a106bc;
  localparam logic [31:0] W_END1   = 32'h55a108bc;
  localparam logic [31:0] W_IDLE   = 32'h55a109bc;
  localparam logic [31:0] W_CC     = 32'h1c1c1cbc;
  localparam logic [3:0]  KC  = 4'b0001;
  localparam logic [3:0]  KD  = 4'b0000;
  localparam logic [3:0]  KCC = 4'b1111;
  localparam logic        H = 1'b1;
  localparam logic        L = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  typedef struct {
    logic        v0;
    logic [31:0] d0;
    logic        l0;
    logic        v1;
    logic [31:0] d1;
    logic        l1;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        r0;
    logic        r1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, tx_enable;
  logic        ch0_valid, ch0_last, ch1_valid, ch1_last;
  logic [31:0] ch0_data, ch1_data;

  logic        m_r0, m_r1, m_busy;
  logic [31:0] m_data;
  logic [3:0]  m_k;
  logic        c_r0, c_r1, c_busy;
  logic [31:0] c_data;
  logic [3:0]  c_k;
`ifdef SFP_TX_SCHED_STATS_EN
  logic [15:0] m_b0, m_b1, m_ccn, c_b0, c_b1, c_ccn;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sfp_tx_scheduler #(.CC_PERIOD(1000), .CC_LEN(4), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .tx_enable(tx_enable),
    .ch0_valid(ch0_valid), .ch0_ready(m_r0), .ch0_data(ch0_data), .ch0_last(ch0_last),
    .ch1_valid(ch1_valid), .ch1_ready(m_r1), .ch1_data(ch1_data), .ch1_last(ch1_last),
    .gt_txdata(m_data), .gt_txcharisk(m_k), .busy(m_busy)
`ifdef SFP_TX_SCHED_STATS_EN
    , .ch0_bursts(m_b0), .ch1_bursts(m_b1), .cc_count(m_ccn)
`endif
  );

  sfp_tx_scheduler #(.CC_PERIOD(16), .CC_LEN(4), .MAX_BURST(4)) dut_cc (
    .clk(clk), .rst(rst), .tx_enable(tx_enable),
    .ch0_valid(ch0_valid), .ch0_ready(c_r0), .ch0_data(ch0_data), .ch0_last(ch0_last),
    .ch1_valid(ch1_valid), .ch1_ready(c_r1), .ch1_data(ch1_data), .ch1_last(ch1_last),
    .gt_txdata(c_data), .gt_txcharisk(c_k), .busy(c_busy)
`ifdef SFP_TX_SCHED_STATS_EN
    , .ch0_bursts(c_b0), .ch1_bursts(c_b1), .cc_count(c_ccn)
`endif
  );

  function automatic vec_t mk(input logic v0, input logic [31:0] d0, input logic l0,
                              input logic v1, input logic [31:0] d1, input logic l1,
                              input logic [31:0] ed, input logic [3:0] ek,
                              input logic r0, input logic r1);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.l0 = l0;
    v.v1 = v1; v.d1 = d1; v.l1 = l1;
    v.ed = ed; v.ek = ek; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    ch0_valid = v.v0; ch0_data = v.d0; ch0_last = v.l0;
    ch1_valid = v.v1; ch1_data = v.d1; ch1_last = v.l1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tx_enable = 1'b1;
    ch0_valid = 1'b0; ch0_data = Z; ch0_last = 1'b0;
    ch1_valid = 1'b0; ch1_data = Z; ch1_last = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_enable = 1'b1;
    ch0_valid = 1'b1; ch0_data = 32'h12345678; ch0_last = 1'b0;
    ch1_valid = 1'b1; ch1_data = 32'h9abcdef0; ch1_last = 1'b0;
    tick();
    tick();
    n_vec++; if (m_data !== W_IDLE) begin n_err++; $display("FAIL reset.data got %h want %h", m_data, W_IDLE); end
    n_vec++; if (m_k !== KC) begin n_err++; $display("FAIL reset.charisk got %b want %b", m_k, KC); end
    n_vec++; if (m_r0 !== 1'b0) begin n_err++; $display("FAIL reset.ch0_ready got %b want 0", m_r0); end
    n_vec++; if (m_r1 !== 1'b0) begin n_err++; $display("FAIL reset.ch1_ready got %b want 0", m_r1); end
    n_vec++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL reset.busy got %b want 0", m_busy); end
    n_vec++; if (c_data !== W_IDLE) begin n_err++; $display("FAIL reset.cc_data got %h want %h", c_data, W_IDLE); end
    n_vec++; if (c_k !== KC) begin n_err++; $display("FAIL reset.cc_charisk got %b want %b", c_k, KC); end
    n_vec++; if (c_busy !== 1'b0) begin n_err++; $display("FAIL reset.cc_busy got %b want 0", c_busy); end
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
    rst = 1'b0;
  endtask

  // Idle lane with CC_PERIOD=16, CC_LEN=4: CC beats on lane cycles 18..21, 34..37.
  task automatic test_cc_idle();
    logic        exp_cc, exp_busy;
    logic [31:0] ed;
    logic [3:0]  ek;
    apply_reset();
    for (int n = 1; n <= 48; n++) begin
      tick();
      exp_cc   = (n >= 18) && (((n - 18) % 16) < 4);
      exp_busy = (n >= 17) && (((n - 17) % 16) < 4);
      ed = exp_cc ? W_CC : W_IDLE;
      ek = exp_cc ? KCC : KC;
      n_vec++; if (c_data !== ed) begin n_err++; $display("FAIL cc_idle.data[%0d] got %h want %h", n, c_data, ed); end
      n_vec++; if (c_k !== ek) begin n_err++; $display("FAIL cc_idle.charisk[%0d] got %b want %b", n, c_k, ek); end
      n_vec++; if (c_busy !== exp_busy) begin n_err++; $display("FAIL cc_idle.busy[%0d] got %b want %b", n, c_busy, exp_busy); end
    end
`ifdef SFP_TX_SCHED_STATS_EN
    n_vec++; if (c_ccn !== 16'd2) begin n_err++; $display("FAIL cc_idle.cc_count got %0d want 2", c_ccn); end
`endif
  endtask

  task automatic test_single_burst();
    vec_t tv[$];
    apply_reset();
    tv.push_back(mk(H, 32'ha0, L, L, Z, L, W_IDLE,   KC, L, L));
    tv.push_back(mk(H, 32'ha0, L, L, Z, L, W_START0, KC, H, L));
    tv.push_back(mk(H, 32'ha0, L, L, Z, L, 32'ha0,   KD, H, L));
    tv.push_back(mk(H, 32'ha1, L, L, Z, L, 32'ha1,   KD, H, L));
    tv.push_back(mk(H, 32'ha2, H, L, Z, L, 32'ha2,   KD, L, L));
    tv.push_back(mk(L, Z,      L, L, Z, L, W_END0,   KC, L, L));
    tv.push_back(mk(L, Z,      L, L, Z, L, W_IDLE,   KC, L, L));
    foreach (tv[i]) begin
      drive(tv[i]);
      tick();
      n_vec++; if (m_data !== tv[i].ed) begin n_err++; $display("FAIL single.data[%0d] got %h want %h", i + 1, m_data, tv[i].ed); end
      n_vec++; if (m_k !== tv[i].ek) begin n_err++; $display("FAIL single.charisk[%0d] got %b want %b", i + 1, m_k, tv[i].ek); end
      n_vec++; if (m_r0 !== tv[i].r0) begin n_err++; $display("FAIL single.ch0_ready[%0d] got %b want %b", i + 1, m_r0, tv[i].r0); end
    end
  endtask

  // ch1 payload deliberately equals the START1 marker: only charisk tells it apart.
  task automatic test_round_robin();
    vec_t tv[$];
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      tv.push_back(mk(H, 32'hdead0000, H, H, W_START1, H, W_IDLE,      KC, L, L));
      tv.push_back(mk(H, 32'hdead0000, H, H, W_START1, H, W_START0,    KC, H, L));
      tv.push_back(mk(H, 32'hdead0000, H, H, W_START1, H, 32'hdead0000, KD, L, L));
      tv.push_back(mk(H, 32'hdead0000, H, H, W_START1, H, W_END0,      KC, L, L));
      tv.push_back(mk(H, 32'hdead0000, H, H, W_START1, H, W_IDLE,      KC, L, L));
      tv.push_back(mk(H, 32'hdead0000, H, H, W_START1, H, W_START1,    KC, L, H));
      tv.push_back(mk(H, 32'hdead0000, H, H, W_START1, H, W_START1,    KD, L, L));
      tv.push_back(mk(H, 32'hdead0000, H, H, W_START1, H, W_END1,      KC, L, L));
    end
    foreach (tv[i]) begin
      drive(tv[i]);
      tick();
      n_vec++; if (m_data !== tv[i].ed) begin n_err++; $display("FAIL rr.data[%0d] got %h want %h", i + 1, m_data, tv[i].ed); end
      n_vec++; if (m_k !== tv[i].ek) begin n_err++; $display("FAIL rr.charisk[%0d] got %b want %b", i + 1, m_k, tv[i].ek); end
      n_vec++; if (m_r0 !== tv[i].r0) begin n_err++; $display("FAIL rr.ch0_ready[%0d] got %b want %b", i + 1, m_r0, tv[i].r0); end
      n_vec++; if (m_r1 !== tv[i].r1) begin n_err++; $display("FAIL rr.ch1_ready[%0d] got %b want %b", i + 1, m_r1, tv[i].r1); end
    end
`ifdef SFP_TX_SCHED_STATS_EN
    n_vec++; if (m_b0 !== 16'd2) begin n_err++; $display("FAIL rr.ch0_bursts got %0d want 2", m_b0); end
    n_vec++; if (m_b1 !== 16'd2) begin n_err++; $display("FAIL rr.ch1_bursts got %0d want 2", m_b1); end
    n_vec++; if (m_ccn !== 16'd0) begin n_err++; $display("FAIL rr.cc_count got %0d want 0", m_ccn); end
`endif
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
  endtask

  // MAX_BURST=4, 6-beat ch1 frame is split across two grants.
  task automatic test_max_burst();
    vec_t tv[$];
    apply_reset();
    tv.push_back(mk(L, Z, L, H, 32'hb0, L, W_IDLE,   KC, L, L));
    tv.push_back(mk(L, Z, L, H, 32'hb0, L, W_START1, KC, L, H));
    tv.push_back(mk(L, Z, L, H, 32'hb0, L, 32'hb0,   KD, L, H));
    tv.push_back(mk(L, Z, L, H, 32'hb1, L, 32'hb1,   KD, L, H));
    tv.push_back(mk(L, Z, L, H, 32'hb2, L, 32'hb2,   KD, L, H));
    tv.push_back(mk(L, Z, L, H, 32'hb3, L, 32'hb3,   KD, L, L));
    tv.push_back(mk(L, Z, L, H, 32'hb4, L, W_END1,   KC, L, L));
    tv.push_back(mk(L, Z, L, H, 32'hb4, L, W_IDLE,   KC, L, L));
    tv.push_back(mk(L, Z, L, H, 32'hb4, L, W_START1, KC, L, H));
    tv.push_back(mk(L, Z, L, H, 32'hb4, L, 32'hb4,   KD, L, H));
    tv.push_back(mk(L, Z, L, H, 32'hb5, H, 32'hb5,   KD, L, L));
    tv.push_back(mk(L, Z, L, L, Z,      L, W_END1,   KC, L, L));
    tv.push_back(mk(L, Z, L, L, Z,      L, W_IDLE,   KC, L, L));
    foreach (tv[i]) begin
      drive(tv[i]);
      tick();
      n_vec++; if (m_data !== tv[i].ed) begin n_err++; $display("FAIL maxb.data[%0d] got %h want %h", i + 1, m_data, tv[i].ed); end
      n_vec++; if (m_k !== tv[i].ek) begin n_err++; $display("FAIL maxb.charisk[%0d] got %b want %b", i + 1, m_k, tv[i].ek); end
      n_vec++; if (m_r1 !== tv[i].r1) begin n_err++; $display("FAIL maxb.ch1_ready[%0d] got %b want %b", i + 1, m_r1, tv[i].r1); end
    end
  endtask

  // last coincides with the MAX_BURST-th beat: one TAIL, no follow-on burst.
  task automatic test_last_at_max();
    vec_t tv[$];
    apply_reset();
    tv.push_back(mk(H, 32'hd0, L, L, Z, L, W_IDLE,   KC, L, L));
    tv.push_back(mk(H, 32'hd0, L, L, Z, L, W_START0, KC, H, L));
    tv.push_back(mk(H, 32'hd0, L, L, Z, L, 32'hd0,   KD, H, L));
    tv.push_back(mk(H, 32'hd1, L, L, Z, L, 32'hd1,   KD, H, L));
    tv.push_back(mk(H, 32'hd2, L, L, Z, L, 32'hd2,   KD, H, L));
    tv.push_back(mk(H, 32'hd3, H, L, Z, L, 32'hd3,   KD, L, L));
    tv.push_back(mk(L, Z,      L, L, Z, L, W_END0,   KC, L, L));
    tv.push_back(mk(L, Z,      L, L, Z, L, W_IDLE,   KC, L, L));
    tv.push_back(mk(L, Z,      L, L, Z, L, W_IDLE,   KC, L, L));
    foreach (tv[i]) begin
      drive(tv[i]);
      tick();
      n_vec++; if (m_data !== tv[i].ed) begin n_err++; $display("FAIL lastmax.data[%0d] got %h want %h", i + 1, m_data, tv[i].ed); end
      n_vec++; if (m_k !== tv[i].ek) begin n_err++; $display("FAIL lastmax.charisk[%0d] got %b want %b", i + 1, m_k, tv[i].ek); end
      n_vec++; if (m_r0 !== tv[i].r0) begin n_err++; $display("FAIL lastmax.ch0_ready[%0d] got %b want %b", i + 1, m_r0, tv[i].r0); end
    end
  endtask

  // Two valid-low cycles inside a ch0 burst must not count toward MAX_BURST.
  task automatic test_valid_stall();
    vec_t tv[$];
    apply_reset();
    tv.push_back(mk(H, 32'hc0, L, L, Z, L, W_IDLE,   KC, L, L));
    tv.push_back(mk(H, 32'hc0, L, L, Z, L, W_START0, KC, H, L));
    tv.push_back(mk(H, 32'hc0, L, L, Z, L, 32'hc0,   KD, H, L));
    tv.push_back(mk(L, 32'hc1, L, L, Z, L, W_IDLE,   KC, H, L));
    tv.push_back(mk(L, 32'hc1, L, L, Z, L, W_IDLE,   KC, H, L));
    tv.push_back(mk(H, 32'hc1, L, L, Z, L, 32'hc1,   KD, H, L));
    tv.push_back(mk(H, 32'hc2, H, L, Z, L, 32'hc2,   KD, L, L));
    tv.push_back(mk(L, Z,      L, L, Z, L, W_END0,   KC, L, L));
    tv.push_back(mk(L, Z,      L, L, Z, L, W_IDLE,   KC, L, L));
    foreach (tv[i]) begin
      drive(tv[i]);
      tick();
      n_vec++; if (m_data !== tv[i].ed) begin n_err++; $display("FAIL stall.data[%0d] got %h want %h", i + 1, m_data, tv[i].ed); end
      n_vec++; if (m_k !== tv[i].ek) begin n_err++; $display("FAIL stall.charisk[%0d] got %b want %b", i + 1, m_k, tv[i].ek); end
      n_vec++; if (m_r0 !== tv[i].r0) begin n_err++; $display("FAIL stall.ch0_ready[%0d] got %b want %b", i + 1, m_r0, tv[i].r0); end
    end
  endtask

  // CC request (cycle 16) lands mid ch0 burst with ch1 waiting; then rst mid-PAYLOAD.
  task automatic test_cc_during_burst();
    vec_t tv[$];
    apply_reset();
    for (int n = 1; n <= 12; n++) tv.push_back(mk(L, Z, L, L, Z, L, W_IDLE, KC, L, L));
    tv.push_back(mk(H, 32'hf0, L, H, 32'h60, L, W_IDLE,   KC, L, L));
    tv.push_back(mk(H, 32'hf0, L, H, 32'h60, L, W_START0, KC, H, L));
    tv.push_back(mk(H, 32'hf0, L, H, 32'h60, L, 32'hf0,   KD, H, L));
    tv.push_back(mk(H, 32'hf1, L, H, 32'h60, L, 32'hf1,   KD, H, L));
    tv.push_back(mk(H, 32'hf2, H, H, 32'h60, L, 32'hf2,   KD, L, L));
    tv.push_back(mk(L, Z,      L, H, 32'h60, L, W_END0,   KC, L, L));
    tv.push_back(mk(L, Z,      L, H, 32'h60, L, W_IDLE,   KC, L, L));
    for (int n = 20; n <= 23; n++) tv.push_back(mk(L, Z, L, H, 32'h60, L, W_CC, KCC, L, L));
    tv.push_back(mk(L, Z,      L, H, 32'h60, L, W_IDLE,   KC, L, L));
    tv.push_back(mk(L, Z,      L, H, 32'h60, L, W_START1, KC, L, H));
    tv.push_back(mk(L, Z,      L, H, 32'h60, L, 32'h60,   KD, L, H));
    tv.push_back(mk(L, Z,      L, H, 32'h60, L, 32'h60,   KD, L, H));
    tv.push_back(mk(L, Z,      L, H, 32'h60, L, 32'h60,   KD, L, H));
    tv.push_back(mk(L, Z,      L, H, 32'h60, L, W_IDLE,   KC, L, L));
    tv.push_back(mk(L, Z,      L, L, Z,      L, W_IDLE,   KC, L, L));
    foreach (tv[i]) begin
      drive(tv[i]);
      rst = (i == 28);
      tick();
      n_vec++; if (c_data !== tv[i].ed) begin n_err++; $display("FAIL ccburst.data[%0d] got %h want %h", i + 1, c_data, tv[i].ed); end
      n_vec++; if (c_k !== tv[i].ek) begin n_err++; $display("FAIL ccburst.charisk[%0d] got %b want %b", i + 1, c_k, tv[i].ek); end
      n_vec++; if (c_r0 !== tv[i].r0) begin n_err++; $display("FAIL ccburst.ch0_ready[%0d] got %b want %b", i + 1, c_r0, tv[i].r0); end
      n_vec++; if (c_r1 !== tv[i].r1) begin n_err++; $display("FAIL ccburst.ch1_ready[%0d] got %b want %b", i + 1, c_r1, tv[i].r1); end
      if (i == 18) begin
        n_vec++; if (c_busy !== 1'b1) begin n_err++; $display("FAIL ccburst.busy_cc got %b want 1", c_busy); end
      end
      if (i >= 28) begin
        n_vec++; if (c_busy !== 1'b0) begin n_err++; $display("FAIL ccburst.busy_rst[%0d] got %b want 0", i + 1, c_busy); end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tx_enable = 1'b0;
    ch0_valid = 1'b0; ch0_data = Z; ch0_last = 1'b0;
    ch1_valid = 1'b0; ch1_data = Z; ch1_last = 1'b0;
    test_reset();
    test_cc_idle();
    test_single_burst();
    test_round_robin();
    test_max_burst();
    test_last_at_max();
    test_valid_stall();
    test_cc_during_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached with %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sfp_tx_scheduler.md
Name: sfp_tx_scheduler

Overview:
- Shares the single 32-bit GT TX lane (gt_txdata/gt_txcharisk into the Aurora 8b10b exdes lane 0) between two stream requesters: ch0 = video, ch1 = auxiliary/control.
- Frames each granted burst with per-channel start/end K-words and fills empty cycles with the idle word.
- Inserts clock-correction sequences periodically.
- Sits between the encoders and the transceiver in the tx_user_clk domain.

Parameters:
- START0, 32'h55a105bc, start marker for ch0 bursts (charisk 4'b0001)
- END0, 32'h55a107bc, end marker for ch0 bursts (charisk 4'b0001)
- START1, 32'h55a106bc, start marker for ch1 bursts (charisk 4'b0001)
- END1, 32'h55a108bc, end marker for ch1 bursts (charisk 4'b0001)
- IDLE_WORD, 32'h55a109bc, fill word (charisk 4'b0001)
- CC_WORD, 32'h1c1c1cbc, clock-correction word (charisk 4'b1111)
- CC_PERIOD, 5000, clk cycles between clock-correction requests; legal range 16..65535
- CC_LEN, 4, consecutive CC_WORD beats per insertion; legal range 1..15
- MAX_BURST, 256, maximum payload beats per grant; legal range 2..65535

Ports:
- clk  in  1  TX user clock
- rst  in  1  synchronous active-high reset
- tx_enable  in  1  link up; grants only issued while high
- ch0_valid  in  1  ch0 payload valid
- ch0_ready  out  1  ch0 payload accepted this cycle
- ch0_data  in  32  ch0 payload
- ch0_last  in  1  ch0 final beat of frame
- ch1_valid  in  1  ch1 payload valid
- ch1_ready  out  1  ch1 payload accepted this cycle
- ch1_data  in  32  ch1 payload
- ch1_last  in  1  ch1 final beat of frame
- gt_txdata  out  32  registered lane data
- gt_txcharisk  out  4  registered K-char flags
- busy  out  1  high in any state other than ARB

Behaviour:
- Interface clocking/reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - gt_txdata = IDLE_WORD, gt_txcharisk = 4'b0001.
  - ch0_ready = ch1_ready = 0, busy = 0.
  - State = ARB, rr pointer = ch0, cc counter = 0, cc_pending = 0.
  - rst mid-burst aborts the burst with no END emitted.
- Outputs are registered: the word selected in a cycle appears on gt_* the next cycle.
- cc counter: free-running 0..CC_PERIOD-1, running regardless of tx_enable. At wrap, set cc_pending (sticky). A wrap occurring while pending is already set is absorbed.
- States:
  - ARB:
    - Output IDLE_WORD.
    - Priority: cc_pending -> CC. Otherwise, if tx_enable and any valid -> HDR, granting round-robin.
    - When both channels are valid, grant the channel not served last; the rr pointer updates on grant.
  - CC: output CC_WORD/4'b1111 for CC_LEN cycles; clear cc_pending on entry; then -> ARB.
  - HDR: output START of the granted channel for 1 cycle; beat counter = 0; -> PAYLOAD.
  - PAYLOAD:
    - chN_ready = 1 for the granted channel only; chN_ready is combinational from state/grant and does not depend on valid.
    - On valid&ready: output data with charisk 4'b0000; increment the beat counter.
    - If valid is low: output IDLE_WORD/4'b0001 and do not count.
    - Exit to TAIL after the beat with last=1, or after the MAX_BURST-th accepted beat, whichever comes first. ready drops in the same cycle as the exit.
  - TAIL: output END of the granted channel for 1 cycle; -> ARB.
- Truncated frames: a frame truncated at MAX_BURST resumes in a later grant under a fresh START. The sink reassembles on chN_last only.
- Boundary cases:
  - tx_enable is sampled only in ARB; deassertion mid-burst lets the burst finish.
  - cc_pending raised mid-burst is serviced at the next ARB, before any grant. Worst-case CC latency is MAX_BURST+3 cycles plus any valid-low stall.
  - last and the MAX_BURST-th beat in the same cycle: single exit to TAIL, no extra burst.
  - A payload data word equal to a marker is never an issue: charisk=0 distinguishes it.
- Minimum burst = 3 lane cycles (HDR, 1 payload beat, TAIL). No idle cycle is inserted between TAIL and the next HDR other than the single ARB cycle.

Optional Feature:
SFP_TX_SCHED_STATS_EN
- Defined: adds outputs ch0_bursts[15:0], ch1_bursts[15:0] and cc_count[15:0].
  - ch0_bursts/ch1_bursts increment on each TAIL for that channel.
  - cc_count increments on each CC entry.
  - All three wrap at 16 bits and are cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, tx_enable=1, no valids, CC_PERIOD=16, CC_LEN=4 -> gt_txdata=55a109bc/0001 steady; every 16 cycles exactly 4 beats of 1c1c1cbc/1111.
2. ch0 sends 3 beats A0,A1,A2(last) continuously -> lane shows 55a105bc/0001, A0, A1, A2 (charisk 0000), 55a107bc/0001, then idle.
3. ch0 and ch1 both continuously valid with 1-beat frames -> grants alternate ch0, ch1, ch0, ...; START/END markers alternate 05/07 then 06/08.
4. MAX_BURST=4, ch1 frame of 6 beats -> START1, 4 beats, END1, ARB idle, START1, 2 beats, END1; ch1_ready=0 during the markers.
5. ch0 valid drops for 2 cycles mid-payload -> 2 IDLE_WORD beats inside the burst, beat count unaffected; the next valid beat is accepted.
6. cc_pending raised during a ch0 burst with ch1 waiting -> burst completes, CC sequence runs, then ch1 is granted; rst asserted mid-PAYLOAD -> next cycle outputs IDLE_WORD with ready=0 and no END.
